// File: rtl/skid_buffer_pkg.sv
// Shared definitions for the skid buffer: state encodings and count width.
// The state value doubles as the occupancy count presented on count_o.
`timescale 1ns/1ps
package skid_buffer_pkg;

    localparam int unsigned COUNT_W = 2;

    localparam logic [COUNT_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [COUNT_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [COUNT_W-1:0] ST_FULL  = 2'd2;

    typedef enum logic [COUNT_W-1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } state_e;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: registered s_ready_o breaks the
// m_ready_i -> s_ready_o path while keeping one word per cycle throughput.
`timescale 1ns/1ps
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int unsigned N_BITS = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [N_BITS-1:0]   s_data_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [N_BITS-1:0]   m_data_o,
    output logic [COUNT_W-1:0]  count_o
);

    state_e              state_q, state_d;
    logic [N_BITS-1:0]   main_q, main_d;
    logic [N_BITS-1:0]   skid_q, skid_d;
    logic                s_ready_q, s_ready_d;
    logic                m_valid_q, m_valid_d;
    logic                in_xfer_c;
    logic                out_xfer_c;

    // Handshakes are qualified by the registered flags only.
    assign in_xfer_c  = s_valid_i & s_ready_q;
    assign out_xfer_c = m_valid_q & m_ready_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer_c) begin
                    main_d  = s_data_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                unique case ({in_xfer_c, out_xfer_c})
                    2'b10: begin
                        skid_d  = s_data_i;
                        state_d = FULL;
                    end
                    2'b01:   state_d = EMPTY;
                    2'b11:   main_d  = s_data_i;
                    default: state_d = BUSY;
                endcase
            end
            FULL: begin
                // s_ready_q is low here, so only the output side can move.
                if (out_xfer_c) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase

        s_ready_d = (state_d != FULL);
        m_valid_d = (state_d != EMPTY);
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = main_q;
    assign count_o   = COUNT_W'(state_q);

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed vectors push expected words,
// a negedge monitor pops and checks every output transfer and the occupancy.
`timescale 1ns/1ps
module tb_skid_buffer;
    import skid_buffer_pkg::*;

    localparam int unsigned N_BITS  = 8;
    localparam int          N_RAND  = 1000;

    logic               clk_i     = 1'b0;
    logic               reset_ni  = 1'b0;
    logic               s_valid_i = 1'b0;
    logic               m_ready_i = 1'b0;
    logic [N_BITS-1:0]  s_data_i  = '0;
    logic               s_ready_o;
    logic               m_valid_o;
    logic [N_BITS-1:0]  m_data_o;
    logic [COUNT_W-1:0] count_o;

    int                 errors = 0;
    int                 checks = 0;
    logic [N_BITS-1:0]  exp_q[$];
    logic [N_BITS-1:0]  words[N_RAND];

    skid_buffer #(.N_BITS(N_BITS)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N_BITS-1:0] d, input logic r);
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: sample mid-cycle, compare against the scoreboard, then log
    // the transfers that will happen at the coming rising edge.
    initial begin
        logic              stall;
        logic [N_BITS-1:0] stall_data;
        stall      = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk_i);
            if (reset_ni) begin
                check("count_vs_model", int'(count_o), exp_q.size());
                check("m_valid_vs_model", int'(m_valid_o), (exp_q.size() != 0) ? 1 : 0);
                if (stall)
                    check("stall_stable", int'(m_data_o), int'(stall_data));
                if (m_valid_o && exp_q.size() != 0)
                    check("m_data_head", int'(m_data_o), int'(exp_q[0]));
                if (m_valid_o && m_ready_i) begin
                    check("output_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0)
                        void'(exp_q.pop_front());
                end
                if (s_valid_i && s_ready_o)
                    exp_q.push_back(s_data_i);
                stall      = m_valid_o && !m_ready_i;
                stall_data = m_data_o;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic acc;

        // Reset state
        drive(1'b0, 8'h00, 1'b0);
        reset_ni = 1'b0;
        #1;
        check("rst_s_ready", int'(s_ready_o), 0);
        check("rst_m_valid", int'(m_valid_o), 0);
        check("rst_count", int'(count_o), int'(ST_EMPTY));
        check("rst_m_data", int'(m_data_o), 0);
        drive(1'b1, 8'hEE, 1'b0);
        repeat (2) tick();
        check("rst_hold_s_ready", int'(s_ready_o), 0);

        // Release: first edge only raises s_ready; EE must not be taken
        @(negedge clk_i);
        #1;
        reset_ni = 1'b1;
        tick();
        check("rel_s_ready", int'(s_ready_o), 1);
        check("rel_m_valid", int'(m_valid_o), 0);
        check("rel_count", int'(count_o), int'(ST_EMPTY));

        // Single word
        drive(1'b1, 8'hA5, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("single_m_valid", int'(m_valid_o), 1);
        check("single_m_data", int'(m_data_o), 8'hA5);
        check("single_count", int'(count_o), int'(ST_BUSY));
        check("single_s_ready", int'(s_ready_o), 1);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("single_drained", int'(count_o), int'(ST_EMPTY));

        // Fill and stall
        drive(1'b1, 8'h11, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("fill_count", int'(count_o), int'(ST_FULL));
        check("fill_s_ready", int'(s_ready_o), 0);
        check("fill_m_data", int'(m_data_o), 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fill_stall_data", int'(m_data_o), 8'h11);
        end
        drive(1'b1, 8'h99, 1'b0);
        tick();
        check("full_ignores_input", int'(count_o), int'(ST_FULL));
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("unstall_m_data", int'(m_data_o), 8'h22);
        check("unstall_count", int'(count_o), int'(ST_BUSY));
        check("unstall_s_ready", int'(s_ready_o), 1);
        tick();
        check("unstall_empty", int'(count_o), int'(ST_EMPTY));

        // Streaming 0..15 with both sides held high
        drive(1'b1, 8'd0, 1'b1);
        tick();
        for (int i = 1; i < 16; i++) begin
            check("stream_m_data", int'(m_data_o), i - 1);
            check("stream_count", int'(count_o), int'(ST_BUSY));
            drive(1'b1, N_BITS'(i), 1'b1);
            tick();
        end
        check("stream_last", int'(m_data_o), 15);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("stream_empty", int'(count_o), int'(ST_EMPTY));

        // Random backpressure on both sides
        for (int i = 0; i < N_RAND; i++)
            words[i] = N_BITS'($urandom);
        idx = 0;
        cyc = 0;
        drive(1'b0, 8'h00, 1'b0);
        while (idx < N_RAND && cyc < 20000) begin
            if (!s_valid_i)
                s_valid_i = ($urandom_range(0, 3) != 0);
            s_data_i  = words[idx];
            m_ready_i = ($urandom_range(0, 2) != 0);
            acc = s_valid_i && s_ready_o;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                s_valid_i = 1'b0;
            end
        end
        check("random_all_sent", idx, N_RAND);
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10 && count_o != ST_EMPTY; i++)
            tick();
        check("random_drain_count", int'(count_o), int'(ST_EMPTY));
        check("random_scoreboard_empty", exp_q.size(), 0);
        drive(1'b0, 8'h00, 1'b0);

        // Asynchronous reset while FULL
        drive(1'b1, 8'h33, 1'b0);
        tick();
        drive(1'b1, 8'h44, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        check("prereset_full", int'(count_o), int'(ST_FULL));
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_m_valid", int'(m_valid_o), 0);
        check("async_count", int'(count_o), int'(ST_EMPTY));
        check("async_s_ready", int'(s_ready_o), 0);
        check("async_m_data", int'(m_data_o), 0);
        exp_q.delete();
        repeat (2) tick();
        @(negedge clk_i);
        #1;
        reset_ni = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("post_s_ready", int'(s_ready_o), 1);
        check("post_m_valid", int'(m_valid_o), 0);
        repeat (3) tick();
        check("post_no_stale", int'(m_valid_o), 0);
        drive(1'b1, 8'h77, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b1);
        check("post_word", int'(m_data_o), 8'h77);
        tick();
        check("post_empty", int'(count_o), int'(ST_EMPTY));
        drive(1'b0, 8'h00, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
